// File: rtl/ov5640_sccb_responder.sv
// SCCB slave for an OV5640-style register file: turns 16-bit-address writes into
// wr_word pulses and serves sequential reads from an external rd_addr/rd_data port.
module ov5640_sccb_responder #(
    parameter logic [7:0] DEVICE_ID  = 8'h78,
    parameter int         ADDR_WIDTH = 16,
    parameter int         DATA_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             sioc,
    input  logic                             siod_in,
    output logic                             siod_oe,
    output logic                             wr_valid,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] wr_word,
    output logic [ADDR_WIDTH-1:0]            rd_addr,
    input  logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             busy
);

    typedef enum logic [3:0] {
        IDLE, ID, ACK_ID, ADDR_H, ACK_AH, ADDR_L, ACK_AL,
        DATA_W, ACK_DW, DATA_R, MACK, WAIT_STOP
    } state_t;

    state_t                state, state_nxt;
    logic                  oe_nxt;
    logic [1:0]            sioc_sync, siod_sync;
    logic                  sioc_q, siod_q;
    logic                  sioc_s, siod_s;
    logic                  sioc_rise, sioc_fall, start_det, stop_det;
    logic [2:0]            bit_cnt;
    logic                  byte_full;
    logic [7:0]            shreg;
    logic [6:0]            tx_shreg;
    logic [7:0]            addr_hi;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            rx_byte, rd_byte;
    logic                  id_match, rx_state, bit_state, bit_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sioc_sync <= 2'b11;
            siod_sync <= 2'b11;
            sioc_q    <= 1'b1;
            siod_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its neighbour.
            sioc_sync <= {sioc_sync[0], sioc};
            siod_sync <= {siod_sync[0], siod_in};
            sioc_q    <= sioc_sync[1];
            siod_q    <= siod_sync[1];
        end
    end

    assign sioc_s    = sioc_sync[1];
    assign siod_s    = siod_sync[1];
    assign sioc_rise = sioc_s & ~sioc_q;
    assign sioc_fall = ~sioc_s & sioc_q;
    // Bus conditions win over a data edge seen in the same clk.
    assign start_det = sioc_s & siod_q & ~siod_s;
    assign stop_det  = sioc_s & ~siod_q & siod_s;

    assign rx_byte   = {shreg[6:0], siod_s};
    assign rd_byte   = 8'(rd_data);
    assign id_match  = (shreg[7:1] == DEVICE_ID[7:1]);
    assign rx_state  = (state == ID) || (state == ADDR_H) || (state == ADDR_L) || (state == DATA_W);
    assign bit_state = rx_state || (state == DATA_R);
    assign bit_last  = sioc_rise && bit_state && !byte_full && (bit_cnt == 3'd7)
                       && !start_det && !stop_det;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            siod_oe <= 1'b0;
        end else begin
            state   <= state_nxt;
            siod_oe <= oe_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        state_nxt = state;
        oe_nxt    = siod_oe;
        if (start_det) begin
            state_nxt = ID;
            oe_nxt    = 1'b0;
        end else if (stop_det) begin
            state_nxt = IDLE;
            oe_nxt    = 1'b0;
        end else if (sioc_fall) begin
            case (state)
                ID: begin
                    if (byte_full) begin
                        if (id_match) begin
                            state_nxt = ACK_ID;
                            oe_nxt    = 1'b1;
                        end else begin
                            state_nxt = WAIT_STOP;
                        end
                    end
                end
                ADDR_H: if (byte_full) begin state_nxt = ACK_AH; oe_nxt = 1'b1; end
                ADDR_L: if (byte_full) begin state_nxt = ACK_AL; oe_nxt = 1'b1; end
                DATA_W: if (byte_full) begin state_nxt = ACK_DW; oe_nxt = 1'b1; end
                ACK_ID: begin
                    // shreg still holds the ID byte; bit 0 is R/W.
                    if (shreg[0]) begin
                        state_nxt = DATA_R;
                        oe_nxt    = ~rd_byte[7];
                    end else begin
                        state_nxt = ADDR_H;
                        oe_nxt    = 1'b0;
                    end
                end
                ACK_AH: begin state_nxt = ADDR_L; oe_nxt = 1'b0; end
                ACK_AL, ACK_DW: begin state_nxt = DATA_W; oe_nxt = 1'b0; end
                DATA_R: begin
                    if (byte_full) begin
                        state_nxt = MACK;
                        oe_nxt    = 1'b0;
                    end else begin
                        oe_nxt    = ~tx_shreg[6];
                    end
                end
                MACK: begin
                    // Only reachable after the master acked on the preceding rise.
                    state_nxt = DATA_R;
                    oe_nxt    = ~rd_byte[7];
                end
                default: ;
            endcase
        end else if (sioc_rise && (state == MACK) && siod_s) begin
            state_nxt = WAIT_STOP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= 3'd0;
            byte_full <= 1'b0;
            shreg     <= 8'd0;
            tx_shreg  <= 7'd0;
            addr_hi   <= 8'd0;
            addr      <= '0;
            rd_addr   <= '0;
            wr_word   <= '0;
            wr_valid  <= 1'b0;
        end else begin
            wr_valid <= 1'b0;

            if (start_det || stop_det || (state_nxt != state)) begin
                bit_cnt   <= 3'd0;
                byte_full <= 1'b0;
            end else if (sioc_rise && bit_state && !byte_full) begin
                bit_cnt   <= bit_cnt + 3'd1;
                byte_full <= (bit_cnt == 3'd7);
                if (rx_state) shreg <= rx_byte;
            end

            if (bit_last) begin
                case (state)
                    ADDR_H: addr_hi <= rx_byte;
                    ADDR_L: addr    <= ADDR_WIDTH'({addr_hi, rx_byte});
                    DATA_W: begin
                        wr_valid <= 1'b1;
                        wr_word  <= {addr, DATA_WIDTH'(rx_byte)};
                    end
                    default: ;
                endcase
            end

            if (!start_det && !stop_det) begin
                if (sioc_rise && (state == MACK) && !siod_s) begin
                    addr    <= addr + ADDR_WIDTH'(1);
                    rd_addr <= addr + ADDR_WIDTH'(1);
                end
                if (sioc_fall) begin
                    case (state)
                        ACK_ID: if (shreg[0]) tx_shreg <= rd_byte[6:0];
                        ACK_DW: addr <= addr + ADDR_WIDTH'(1);
                        DATA_R: if (!byte_full) tx_shreg <= {tx_shreg[5:0], 1'b0};
                        MACK:   tx_shreg <= rd_byte[6:0];
                        default: ;
                    endcase
                end
            end

            if ((state == ID) && (state_nxt == ACK_ID)) rd_addr <= addr;
        end
    end

endmodule

// File: tb/tb_ov5640_sccb_responder.sv
// Bench for ov5640_sccb_responder: bit-banged SCCB master, register-file model
// and a write scoreboard, with directed cases followed by random transactions.
module tb_ov5640_sccb_responder;

    localparam int TQ = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sioc = 1'b1;
    logic        sda_m = 1'b1;
    logic        siod_line;
    logic        siod_oe;
    logic        wr_valid;
    logic [23:0] wr_word;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic        busy;

    logic [7:0]  mem [0:65535];
    logic [23:0] wr_log [$];
    logic [23:0] exp_wr [$];
    logic [7:0]  wdata [$];
    int          wr_seen = 0;
    int          oe_cycles = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] model_ptr = 16'h0000;

    assign siod_line = sda_m & ~siod_oe;
    assign rd_data   = mem[rd_addr];

    always #5 clk = ~clk;

    ov5640_sccb_responder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sioc     (sioc),
        .siod_in  (siod_line),
        .siod_oe  (siod_oe),
        .wr_valid (wr_valid),
        .wr_word  (wr_word),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy)
    );

    always @(negedge clk) begin
        if (wr_valid) wr_log.push_back(wr_word);
        if (siod_oe) oe_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_bit(input logic b, output logic seen);
        wait_clk(2);
        sda_m = b;
        wait_clk(TQ);
        sioc = 1'b1;
        wait_clk(TQ);
        seen = siod_line;
        wait_clk(TQ);
        sioc = 1'b0;
    endtask

    task automatic bus_start();
        wait_clk(2);
        sda_m = 1'b1;
        wait_clk(TQ);
        sioc = 1'b1;
        wait_clk(TQ);
        sda_m = 1'b0;
        wait_clk(TQ);
        sioc = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(2);
        sda_m = 1'b0;
        wait_clk(TQ);
        sioc = 1'b1;
        wait_clk(TQ);
        sda_m = 1'b1;
        wait_clk(TQ);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        logic s;
        for (int i = 0; i < n; i++) bus_bit(b[7-i], s);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        logic s;
        send_bits(b, 8);
        bus_bit(1'b1, s);
        acked = ~s;
    endtask

    task automatic recv_byte(input bit master_ack, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bus_bit(1'b1, s);
            d = {d[6:0], s};
        end
        bus_bit(master_ack ? 1'b0 : 1'b1, s);
    endtask

    // Writes address a followed by the bytes in wdata; the register file sees
    // one word per byte at consecutive addresses.
    task automatic write_txn(input logic [15:0] a, input bit stop);
        logic        ack;
        logic [15:0] wa;
        bus_start();
        send_byte(8'h78, ack);  check("ack_id", ack, 1);
        send_byte(a[15:8], ack); check("ack_ah", ack, 1);
        send_byte(a[7:0], ack);  check("ack_al", ack, 1);
        for (int k = 0; k < wdata.size(); k++) begin
            send_byte(wdata[k], ack);
            check("ack_dw", ack, 1);
            wa = a + 16'(k);
            exp_wr.push_back({wa, wdata[k]});
        end
        model_ptr = a + 16'(wdata.size());
        if (stop) begin
            bus_stop();
            check("busy_after_stop", busy, 0);
        end
    endtask

    task automatic read_txn(input int n);
        logic        ack;
        logic [7:0]  d;
        logic [15:0] p, pk;
        bus_start();
        send_byte(8'h79, ack);
        check("ack_rid", ack, 1);
        p = model_ptr;
        for (int k = 0; k < n; k++) begin
            recv_byte(k < n - 1, d);
            pk = p + 16'(k);
            check("rd_byte", d, mem[pk]);
        end
        pk = p + 16'(n - 1);
        check("rd_addr", rd_addr, pk);
        model_ptr = pk;
        bus_stop();
        check("busy_after_stop", busy, 0);
    endtask

    task automatic bad_txn(input logic [7:0] id, input int nb);
        logic       ack;
        logic [7:0] b;
        int         oe0;
        bus_start();
        oe0 = oe_cycles;
        send_byte(id, ack);
        check("nack_id", ack, 0);
        for (int k = 0; k < nb; k++) begin
            b = 8'($urandom);
            send_byte(b, ack);
            check("nack_byte", ack, 0);
        end
        check("busy_foreign", busy, 1);
        check("oe_quiet", oe_cycles - oe0, 0);
        bus_stop();
        check("busy_after_stop", busy, 0);
    endtask

    task automatic verify_writes(input string tag);
        check("wr_count", wr_log.size() - wr_seen, exp_wr.size());
        for (int i = 0; i < exp_wr.size(); i++)
            if (wr_seen + i < wr_log.size()) check(tag, wr_log[wr_seen + i], exp_wr[i]);
        wr_seen = wr_log.size();
        exp_wr.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          mode, n;
        logic [15:0] a;
        logic [7:0]  id;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h300A] = 8'h56;

        wait_clk(5);
        check("rst_oe", siod_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_wr_word", wr_word, 0);
        check("rst_rd_addr", rd_addr, 0);
        rst_n = 1'b1;
        wait_clk(5);

        wdata.delete(); wdata.push_back(8'h82);
        write_txn(16'h3008, 1);
        verify_writes("basic_wr");

        bad_txn(8'h42, 3);
        verify_writes("foreign_wr");

        wdata.delete(); wdata.push_back(8'h11); wdata.push_back(8'h22);
        write_txn(16'hFFFF, 1);
        verify_writes("wrap_wr");

        wdata.delete();
        write_txn(16'h300A, 1);
        read_txn(1);
        check("read_idle", busy, 0);

        // Reset while the master is mid-way through ADDR_L bit 3.
        wdata.delete();
        bus_start();
        begin
            logic ack;
            send_byte(8'h78, ack); check("ack_id", ack, 1);
            send_byte(8'h31, ack); check("ack_ah", ack, 1);
        end
        send_bits(8'h03, 4);
        wait_clk(2);
        sda_m = 1'b0;
        wait_clk(TQ);
        sioc = 1'b1;
        wait_clk(2);
        check("busy_pre_rst", busy, 1);
        rst_n = 1'b0;
        sda_m = 1'b1;
        wait_clk(1);
        check("midrst_oe", siod_oe, 0);
        check("midrst_busy", busy, 0);
        check("midrst_rd_addr", rd_addr, 0);
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(6);
        model_ptr = 16'h0000;
        verify_writes("midrst_wr");
        wdata.delete(); wdata.push_back(8'h11);
        write_txn(16'h3103, 1);
        verify_writes("post_rst_wr");

        // STOP after five data bits of a write.
        wdata.delete();
        write_txn(16'h4242, 0);
        send_bits(8'hA5, 5);
        bus_stop();
        check("trunc_busy", busy, 0);
        verify_writes("trunc_wr");

        for (int it = 0; it < 24; it++) begin
            mode = $urandom_range(0, 3);
            n    = $urandom_range(1, 3);
            a    = 16'($urandom);
            if ($urandom_range(0, 5) == 0) a = 16'hFFFF - 16'($urandom_range(0, 1));
            case (mode)
                0: begin
                    wdata.delete();
                    for (int k = 0; k < n; k++) wdata.push_back(8'($urandom));
                    write_txn(a, 1);
                end
                1: begin
                    wdata.delete();
                    write_txn(a, 0);
                    read_txn(n);
                end
                2: read_txn(n);
                default: begin
                    id = 8'($urandom);
                    while (id[7:1] == 7'h3C) id = 8'($urandom);
                    bad_txn(id, n - 1);
                end
            endcase
            verify_writes("rand_wr");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ov5640_sccb_responder.md
OV5640_SCCB_RESPONDER -- requirements
Module: ov5640_sccb_responder

Interface
REQ-001 SHALL have parameter DEVICE_ID, default 8'h78, 7-bit SCCB write ID in [7:1]; the read ID is DEVICE_ID|1.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, register sub-address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, register data width.
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port sioc, input, 1, SCCB clock from the initiator, asynchronous to clk.
REQ-007 SHALL have port siod_in, input, 1, sampled SCCB data line, asynchronous to clk.
REQ-008 SHALL have port siod_oe, output, 1, open-drain pull-low enable (1 = drive SIOD low).
REQ-009 SHALL have port wr_valid, output, 1, one-clk pulse per completed write byte.
REQ-010 SHALL have port wr_word, output, 24, {addr[15:0], data[7:0]} in the same packing as init-table entries.
REQ-011 SHALL have port rd_addr, output, 16, the register address being read.
REQ-012 SHALL have port rd_data, input, 8, register content for rd_addr, valid 1 clk after rd_addr changes.
REQ-013 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL synchronise sioc and siod_in through 2 flops each, then edge-detect; SIOC high and low phases are >= 4 clk each.
REQ-015 SHALL detect START as a synced SIOD fall while SIOC is high, and STOP as a synced SIOD rise while SIOC is high.
REQ-016 SHALL sample bits MSB first on the SIOC rise and change siod_oe only on the SIOC fall.
REQ-017 SHALL use FSM states IDLE, ID, ACK_ID, ADDR_H, ACK_AH, ADDR_L, ACK_AL, DATA_W, ACK_DW, DATA_R, MACK, WAIT_STOP, with a 3-bit bit counter per byte.
REQ-018 SHALL go from IDLE to ID on START, and from any state to ID on START (repeated start).
REQ-019 SHALL go from any state to IDLE on STOP, releasing siod_oe on the same clk.
REQ-020 SHALL, when ID[7:1] matches: ACK and go to ADDR_H if the R/W bit is 0, or to DATA_R if it is 1; on mismatch, go to WAIT_STOP without ACK.
REQ-021 SHALL assert siod_oe from the SIOC fall after the 8th bit to the next SIOC fall (the ACK slot) in ACK_ID, ACK_AH, ACK_AL and ACK_DW.
REQ-022 SHALL load address bits [15:8] in ADDR_H and [7:0] in ADDR_L, with the internal address register updated at the end of ADDR_L.
REQ-023 SHALL, in DATA_W, pulse wr_valid one clk at the 8th-bit SIOC rise, with wr_word = {addr, data} held until the next pulse.
REQ-024 SHALL, after ACK_DW, increment addr by 1 (16-bit wrap 0xFFFF->0x0000) and return to DATA_W.
REQ-025 SHALL, in read: drive rd_addr = addr from entry to ACK_ID; latch rd_data at the SIOC fall ending ACK_ID; shift it out with siod_oe = ~bit.
REQ-026 SHALL, in MACK: release siod_oe and sample the master bit; on 0 (ACK), increment addr and return to DATA_R with a new latch; on 1 (NACK), go to WAIT_STOP.
REQ-027 SHALL, if START and STOP conditions coincide with a data edge, give START/STOP priority over bit sampling.
REQ-028 SHALL produce no wr_valid for a DATA_W byte truncated by STOP or START.

Reset
REQ-029 SHALL, while rst_n is low: state = IDLE, siod_oe = 0, wr_valid = 0, wr_word = 0, rd_addr = 0, busy = 0, addr = 0, synchronisers = 1.
REQ-030 SHALL abandon any transfer on reset mid-transaction, with no partial wr_valid, and wait for a fresh START.

Verification
REQ-031 SHALL verify: START, 0x78, 0x30, 0x08, 0x82, STOP -> four ACK slots low; one wr_valid with wr_word = 24'h3008_82.
REQ-032 SHALL verify: START, 0x42, ... -> siod_oe stays 0 for the whole transfer; no wr_valid; busy drops at STOP.
REQ-033 SHALL verify: write addr 0xFFFF with data 0x11, 0x22 -> wr_word 24'hFFFF_11 then 24'h0000_22.
REQ-034 SHALL verify: write addr 0x300A, STOP; START 0x79; rd_data = 0x56; master NACK -> rd_addr = 0x300A; SIOD bits 0,1,0,1,0,1,1,0; idle after STOP.
REQ-035 SHALL verify: rst_n pulsed low during ADDR_L bit 3 -> siod_oe = 0 and busy = 0 immediately; no wr_valid; the following full write to 0x3103/0x11 decodes correctly.
REQ-036 SHALL verify: STOP after 5 DATA_W bits -> no wr_valid; state = IDLE.
